// File: rtl/reg_bank.sv
// Parametrised register bank: DEPTH x WIDTH registers with load/clear/inc/dec/shift
// ops, zero/carry flags of the last executed op, and two forwarding read ports.
module reg_bank #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
   input  logic             CLK,
   input  logic             CLR_N,
   input  logic             En,
   input  logic [2:0]       Op,
   input  logic [AW-1:0]    WA,
   input  logic [WIDTH-1:0] BS,
   input  logic [AW-1:0]    RA_A,
   input  logic [AW-1:0]    RA_B,
   output logic [WIDTH-1:0] DA,
   output logic [WIDTH-1:0] DB,
   output logic             Z,
   output logic             C
);

   typedef enum logic [2:0] {
      OP_HOLD  = 3'd0,
      OP_LOAD  = 3'd1,
      OP_CLEAR = 3'd2,
      OP_INC   = 3'd3,
      OP_DEC   = 3'd4,
      OP_SHL   = 3'd5,
      OP_SHR   = 3'd6,
      OP_RSVD  = 3'd7
   } op_e;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [WIDTH-1:0] cur_val;
   logic [WIDTH-1:0] new_val;
   logic             new_c;
   logic             op_ok;
   logic             wa_ok;
   logic             wr_en;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   always_comb begin
      cur_val = '0;
      wa_ok   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(WA) == i) begin
            cur_val = regs[i];
            wa_ok   = 1'b1;
         end
      end
   end

   always_comb begin
      new_val = cur_val;
      new_c   = 1'b0;
      op_ok   = 1'b1;
      case (op_e'(Op))
         OP_LOAD:  new_val = BS;
         OP_CLEAR: new_val = '0;
         OP_INC: begin
            new_val = cur_val + WIDTH'(1);
            new_c   = &cur_val;
         end
         OP_DEC: begin
            new_val = cur_val - WIDTH'(1);
            new_c   = ~|cur_val;
         end
         OP_SHL: begin
            new_val = {cur_val[WIDTH-2:0], 1'b0};
            new_c   = cur_val[WIDTH-1];
         end
         OP_SHR: begin
            new_val = {1'b0, cur_val[WIDTH-1:1]};
            new_c   = cur_val[0];
         end
         default:  op_ok = 1'b0;
      endcase
   end

   assign wr_en = En & op_ok & wa_ok;

   // Read muxes see the result being written this edge (write-through).
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(RA_A) == i) rd_a = (wr_en && int'(WA) == i) ? new_val : regs[i];
         if (int'(RA_B) == i) rd_b = (wr_en && int'(WA) == i) ? new_val : regs[i];
      end
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         DA <= '0;
         DB <= '0;
         Z  <= 1'b0;
         C  <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && int'(WA) == i) regs[i] <= new_val;
         end
         if (wr_en) begin
            Z <= ~|new_val;
            C <= new_c;
         end
         DA <= rd_a;
         DB <= rd_b;
      end
   end

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: two instances (DEPTH=4 and DEPTH=3) share stimulus,
// an arithmetic reference model predicts outputs and a monitor checks them each cycle.
module tb_reg_bank;

   logic       CLK = 1'b0;
   logic       CLR_N = 1'b0;
   logic       En = 1'b0;
   logic [2:0] Op = 3'd0;
   logic [1:0] WA = 2'd0;
   logic [1:0] RA_A = 2'd0;
   logic [1:0] RA_B = 2'd0;
   logic [7:0] BS = 8'd0;
   logic [7:0] da4, db4, da3, db3;
   logic       z4, c4, z3, c3;

   always #5 CLK = ~CLK;

   reg_bank #(.WIDTH(8), .DEPTH(4)) dut4 (
      .CLK(CLK), .CLR_N(CLR_N), .En(En), .Op(Op), .WA(WA), .BS(BS),
      .RA_A(RA_A), .RA_B(RA_B), .DA(da4), .DB(db4), .Z(z4), .C(c4)
   );

   reg_bank #(.WIDTH(8), .DEPTH(3)) dut3 (
      .CLK(CLK), .CLR_N(CLR_N), .En(En), .Op(Op), .WA(WA), .BS(BS),
      .RA_A(RA_A), .RA_B(RA_B), .DA(da3), .DB(db3), .Z(z3), .C(c3)
   );

   typedef struct {
      logic [7:0] da;
      logic [7:0] db;
      logic       z;
      logic       c;
   } exp_t;

   exp_t q4[$];
   exp_t q3[$];

   int mem [2][4];
   int zf [2];
   int cf [2];
   int dep [2] = '{4, 3};
   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) mem[k][i] = 0;
         zf[k] = 0;
         cf[k] = 0;
      end
   endfunction

   // Applies the sampled inputs to the model of each bank and queues the expected outputs.
   task automatic model_step();
      int r, n, cy;
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (En && Op >= 1 && Op <= 6 && int'(WA) < dep[k]) begin
            r  = mem[k][WA];
            n  = r;
            cy = 0;
            case (Op)
               3'd1: n = int'(BS);
               3'd2: n = 0;
               3'd3: begin n = (r + 1) % 256;   cy = (r == 255); end
               3'd4: begin n = (r + 255) % 256; cy = (r == 0);   end
               3'd5: begin n = (r * 2) % 256;   cy = (r >= 128); end
               3'd6: begin n = r / 2;           cy = r % 2;      end
               default: n = r;
            endcase
            mem[k][WA] = n;
            zf[k] = (n == 0);
            cf[k] = cy;
         end
         e.da = (int'(RA_A) < dep[k]) ? 8'(mem[k][RA_A]) : 8'h00;
         e.db = (int'(RA_B) < dep[k]) ? 8'(mem[k][RA_B]) : 8'h00;
         e.z  = zf[k][0];
         e.c  = cf[k][0];
         if (k == 0) q4.push_back(e);
         else        q3.push_back(e);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (q4.size() > 0) begin
         e = q4.pop_front();
         chk("d4.DA", da4, e.da);
         chk("d4.DB", db4, e.db);
         chk("d4.Z", {7'd0, z4}, {7'd0, e.z});
         chk("d4.C", {7'd0, c4}, {7'd0, e.c});
      end
      if (q3.size() > 0) begin
         e = q3.pop_front();
         chk("d3.DA", da3, e.da);
         chk("d3.DB", db3, e.db);
         chk("d3.Z", {7'd0, z3}, {7'd0, e.z});
         chk("d3.C", {7'd0, c3}, {7'd0, e.c});
      end
   end

   task automatic cyc(input logic en, input logic [2:0] op, input logic [1:0] wa,
                      input logic [7:0] bs, input logic [1:0] ra, input logic [1:0] rb);
      En = en; Op = op; WA = wa; BS = bs; RA_A = ra; RA_B = rb;
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " d4.DA"}, da4, 8'h00);
      chk({tag, " d4.DB"}, db4, 8'h00);
      chk({tag, " d4.ZC"}, {6'd0, z4, c4}, 8'h00);
      chk({tag, " d3.DA"}, da3, 8'h00);
      chk({tag, " d3.DB"}, db3, 8'h00);
      chk({tag, " d3.ZC"}, {6'd0, z3, c3}, 8'h00);
   endtask

   // Reset pulse placed mid-cycle, released mid-cycle after an edge has passed.
   task automatic do_reset();
      @(negedge CLK);
      En = 1'b0;
      #2;
      CLR_N = 1'b0;
      #1;
      check_zero("async rst");
      model_reset();
      @(posedge CLK);
      #3;
      CLR_N = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      #2;
      check_zero("power-on rst");
      #6;
      CLR_N = 1'b1;
      cyc(1, 3'd1, 2'd0, 8'h5A, 2'd0, 2'd0);

      do_reset();
      cyc(1, 3'd1, 2'd2, 8'hA5, 2'd2, 2'd0);

      // wrap-around on r1
      cyc(1, 3'd1, 2'd1, 8'hFF, 2'd1, 2'd2);
      cyc(1, 3'd3, 2'd1, 8'h00, 2'd1, 2'd2);
      cyc(1, 3'd4, 2'd1, 8'h00, 2'd1, 2'd0);

      // shifts on r0
      cyc(1, 3'd1, 2'd0, 8'h81, 2'd0, 2'd1);
      cyc(1, 3'd5, 2'd0, 8'h00, 2'd0, 2'd1);
      cyc(1, 3'd6, 2'd0, 8'h00, 2'd0, 2'd1);
      cyc(1, 3'd6, 2'd0, 8'h00, 2'd0, 2'd2);

      // forwarding: both ports read the register written this edge
      cyc(1, 3'd1, 2'd3, 8'h3C, 2'd3, 2'd3);
      cyc(1, 3'd1, 2'd2, 8'hC3, 2'd2, 2'd2);

      // no-ops: disabled, reserved op, out-of-range address on the 3-deep bank
      cyc(0, 3'd2, 2'd1, 8'h00, 2'd1, 2'd2);
      cyc(1, 3'd7, 2'd1, 8'h00, 2'd1, 2'd0);
      cyc(1, 3'd0, 2'd2, 8'h00, 2'd2, 2'd3);
      cyc(1, 3'd2, 2'd3, 8'h00, 2'd3, 2'd1);
      cyc(1, 3'd1, 2'd3, 8'h77, 2'd3, 2'd0);

      // reset between INC edges
      cyc(1, 3'd1, 2'd0, 8'h10, 2'd0, 2'd0);
      cyc(1, 3'd3, 2'd0, 8'h00, 2'd0, 2'd1);
      cyc(1, 3'd3, 2'd0, 8'h00, 2'd0, 2'd1);
      do_reset();
      cyc(0, 3'd0, 2'd0, 8'h00, 2'd0, 2'd1);
      cyc(0, 3'd0, 2'd0, 8'h00, 2'd2, 2'd3);
      cyc(1, 3'd3, 2'd0, 8'h00, 2'd0, 2'd0);
      cyc(1, 3'd3, 2'd0, 8'h00, 2'd0, 2'd1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 8'($urandom), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)));
         if (n == 200) do_reset();
      end

      @(negedge CLK);
      #1;
      n_checks++;
      if (q4.size() != 0 || q3.size() != 0) begin
         n_fail++;
         $display("FAIL drain: queues hold %0d/%0d entries, expected 0/0", q4.size(), q3.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
